// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencer: stores a BCD-loaded alarm time, rings on a once-per-second
// match against the running clock, and supports stop, snooze and ring timeout.
module alarm_seq_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic [5:0] tmp_hour,
    input  logic [5:0] tmp_minute,
    input  logic [5:0] tmp_second,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_alarm,
    input  logic       LD_time,
    input  logic       AL_ON,
    input  logic       STOP_al,
    input  logic       snooze,
    output logic       Alarm,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZED = 2'd3
    } state_t;

    localparam int SNZ_M = SNOOZE_MIN % 60;
    localparam int SNZ_H = (SNOOZE_MIN / 60) % 24;
    localparam int RC_W  = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

    state_t          r_state, w_state_next;
    logic            r_alarm, w_alarm_next;
    logic [5:0]      r_alarm_hour, w_alarm_hour_next;
    logic [5:0]      r_alarm_min, w_alarm_min_next;
    logic            r_err, w_err_next;
    logic            r_bad_q;
    logic [5:0]      r_snz_hour, w_snz_hour_next;
    logic [5:0]      r_snz_min, w_snz_min_next;
    logic [RC_W-1:0] r_ring_cnt, w_ring_cnt_next;

    // BCD load decode and range check
    logic [7:0] w_ld_hour, w_ld_min;
    logic       w_ld_valid, w_ld_ok, w_ld_bad;

    assign w_ld_hour  = ({6'd0, H_in1} * 8'd10) + {4'd0, H_in0};
    assign w_ld_min   = ({4'd0, M_in1} * 8'd10) + {4'd0, M_in0};
    assign w_ld_valid = (H_in0 <= 4'd9) && (M_in1 <= 4'd9) && (M_in0 <= 4'd9)
                     && (w_ld_hour <= 8'd23) && (w_ld_min <= 8'd59);
    assign w_ld_ok    = LD_alarm && w_ld_valid;
    assign w_ld_bad   = LD_alarm && !w_ld_valid;

    // Snooze target: now + SNOOZE_MIN, minutes mod 60 with carry, hours mod 24
    logic [6:0] w_min_sum, w_hour_sum;
    logic       w_min_carry;
    logic [5:0] w_snz_min_calc, w_snz_hour_calc;

    assign w_min_sum       = {1'b0, tmp_minute} + 7'(SNZ_M);
    assign w_min_carry     = (w_min_sum >= 7'd60);
    assign w_snz_min_calc  = 6'(w_min_carry ? (w_min_sum - 7'd60) : w_min_sum);
    assign w_hour_sum      = {1'b0, tmp_hour} + 7'(SNZ_H) + {6'd0, w_min_carry};
    assign w_snz_hour_calc = 6'((w_hour_sum >= 7'd24) ? (w_hour_sum - 7'd24) : w_hour_sum);

    // A match is only taken on the tick, so each second-zero is seen exactly once
    logic [5:0] w_tgt_hour, w_tgt_min;
    logic       w_match;

    assign w_tgt_hour = (r_state == SNOOZED) ? r_snz_hour : r_alarm_hour;
    assign w_tgt_min  = (r_state == SNOOZED) ? r_snz_min  : r_alarm_min;
    assign w_match    = tick_1s && !LD_time && (tmp_second == 6'd0)
                     && (tmp_hour == w_tgt_hour) && (tmp_minute == w_tgt_min);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_alarm      <= 1'b0;
            r_alarm_hour <= 6'd0;
            r_alarm_min  <= 6'd0;
            r_err        <= 1'b0;
            r_bad_q      <= 1'b0;
            r_snz_hour   <= 6'd0;
            r_snz_min    <= 6'd0;
            r_ring_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_alarm      <= w_alarm_next;
            r_alarm_hour <= w_alarm_hour_next;
            r_alarm_min  <= w_alarm_min_next;
            r_err        <= w_err_next;
            r_bad_q      <= w_ld_bad;
            r_snz_hour   <= w_snz_hour_next;
            r_snz_min    <= w_snz_min_next;
            r_ring_cnt   <= w_ring_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_alarm_hour_next = r_alarm_hour;
        w_alarm_min_next  = r_alarm_min;
        w_snz_hour_next   = r_snz_hour;
        w_snz_min_next    = r_snz_min;
        w_ring_cnt_next   = r_ring_cnt;
        // A held rejected load reports once, not every cycle
        w_err_next        = w_ld_bad && !r_bad_q;

        if (w_ld_ok) begin
            w_alarm_hour_next = w_ld_hour[5:0];
            w_alarm_min_next  = w_ld_min[5:0];
            w_snz_hour_next   = 6'd0;
            w_snz_min_next    = 6'd0;
        end

        if (!AL_ON) begin
            w_state_next = IDLE;
        end else if (w_ld_ok) begin
            w_state_next = ARMED;
        end else begin
            case (r_state)
                IDLE: w_state_next = ARMED;
                ARMED: begin
                    if (w_match) begin
                        w_state_next    = RINGING;
                        w_ring_cnt_next = '0;
                    end
                end
                RINGING: begin
                    if (STOP_al) begin
                        w_state_next = ARMED;
                    end else if (snooze) begin
                        w_state_next    = SNOOZED;
                        w_snz_hour_next = w_snz_hour_calc;
                        w_snz_min_next  = w_snz_min_calc;
                    end else if (tick_1s) begin
                        if (r_ring_cnt == RC_W'(RING_SEC - 1))
                            w_state_next = ARMED;
                        else
                            w_ring_cnt_next = r_ring_cnt + 1'b1;
                    end
                end
                SNOOZED: begin
                    if (STOP_al) begin
                        w_state_next = ARMED;
                    end else if (w_match) begin
                        w_state_next    = RINGING;
                        w_ring_cnt_next = '0;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end

        w_alarm_next = (w_state_next == RINGING);
    end

    assign Alarm        = r_alarm;
    assign alarm_hour   = r_alarm_hour;
    assign alarm_minute = r_alarm_min;
    assign alarm_err    = r_err;
    assign state        = r_state;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Directed bench for alarm_seq_ctrl: load, ring/stop, timeout, snooze wrap,
// priority/suppression and asynchronous reset.
module tb_alarm_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1s;
    logic [5:0] tmp_hour, tmp_minute, tmp_second;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_alarm, LD_time, AL_ON, STOP_al, snooze;
    logic       Alarm;
    logic [5:0] alarm_hour, alarm_minute;
    logic       alarm_err;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;

    alarm_seq_ctrl #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s),
        .tmp_hour(tmp_hour), .tmp_minute(tmp_minute), .tmp_second(tmp_second),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_alarm(LD_alarm), .LD_time(LD_time), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .snooze(snooze),
        .Alarm(Alarm), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_err(alarm_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        tmp_hour = 6'(h); tmp_minute = 6'(m); tmp_second = 6'(s);
        tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
    endtask

    task automatic load(input int h1, input int h0, input int m1, input int m0);
        H_in1 = 2'(h1); H_in0 = 4'(h0); M_in1 = 4'(m1); M_in0 = 4'(m0);
        LD_alarm = 1'b1;
        cyc();
        LD_alarm = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({state, Alarm, alarm_hour, alarm_minute, alarm_err} !== 16'd0) begin
            $display("FAIL reset_vals got=%h exp=0", {state, Alarm, alarm_hour, alarm_minute, alarm_err});
            n_bad++;
        end
        #2 reset = 1'b1;
        cyc(); cyc();
        n_total++;
        if ({state, Alarm} !== {2'd0, 1'b0}) begin
            $display("FAIL reset_idle got state=%0d alarm=%0d exp state=0 alarm=0", state, Alarm);
            n_bad++;
        end
        $display("test_reset done");
    endtask

    task automatic test_load();
        load(0, 1, 2, 0);
        n_total++;
        if ({alarm_hour, alarm_minute, alarm_err, state} !== {6'd1, 6'd20, 1'b0, 2'd0}) begin
            $display("FAIL load_ok got %0d:%0d err=%0d st=%0d exp 1:20 err=0 st=0", alarm_hour, alarm_minute, alarm_err, state);
            n_bad++;
        end
        load(2, 5, 2, 0);
        n_total++;
        if ({alarm_hour, alarm_minute, alarm_err} !== {6'd1, 6'd20, 1'b1}) begin
            $display("FAIL load_h25 got %0d:%0d err=%0d exp 1:20 err=1", alarm_hour, alarm_minute, alarm_err);
            n_bad++;
        end
        cyc();
        n_total++;
        if (alarm_err !== 1'b0) begin
            $display("FAIL err_pulse_end got=%0d exp=0", alarm_err);
            n_bad++;
        end
        load(0, 1, 2, 10);
        n_total++;
        if ({alarm_hour, alarm_minute, alarm_err} !== {6'd1, 6'd20, 1'b1}) begin
            $display("FAIL load_bcd10 got %0d:%0d err=%0d exp 1:20 err=1", alarm_hour, alarm_minute, alarm_err);
            n_bad++;
        end
        cyc();
        load(0, 1, 6, 0);
        n_total++;
        if ({alarm_hour, alarm_minute, alarm_err} !== {6'd1, 6'd20, 1'b1}) begin
            $display("FAIL load_m60 got %0d:%0d err=%0d exp 1:20 err=1", alarm_hour, alarm_minute, alarm_err);
            n_bad++;
        end
        cyc();
        // held invalid load: a single err pulse
        H_in1 = 2'd3; H_in0 = 4'd0; M_in1 = 4'd0; M_in0 = 4'd0; LD_alarm = 1'b1;
        cyc();
        n_total++;
        if (alarm_err !== 1'b1) begin
            $display("FAIL held_bad_c1 got=%0d exp=1", alarm_err);
            n_bad++;
        end
        cyc(); cyc();
        n_total++;
        if (alarm_err !== 1'b0) begin
            $display("FAIL held_bad_c3 got=%0d exp=0", alarm_err);
            n_bad++;
        end
        // held valid load: idempotent
        H_in1 = 2'd1; H_in0 = 4'd2; M_in1 = 4'd3; M_in0 = 4'd4;
        cyc(); cyc();
        LD_alarm = 1'b0;
        n_total++;
        if ({alarm_hour, alarm_minute, alarm_err} !== {6'd12, 6'd34, 1'b0}) begin
            $display("FAIL load_hold got %0d:%0d err=%0d exp 12:34 err=0", alarm_hour, alarm_minute, alarm_err);
            n_bad++;
        end
        load(0, 1, 2, 0);
        $display("test_load done");
    endtask

    task automatic test_ring();
        AL_ON = 1'b1;
        cyc();
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL armed got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        tmp_hour = 6'd1; tmp_minute = 6'd20; tmp_second = 6'd0;
        cyc();
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL no_tick_match got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        tick_at(1, 19, 59);
        tick_at(1, 20, 0);
        n_total++;
        if ({state, Alarm} !== {2'd2, 1'b1}) begin
            $display("FAIL ring_start got st=%0d al=%0d exp st=2 al=1", state, Alarm);
            n_bad++;
        end
        STOP_al = 1'b1;
        cyc();
        STOP_al = 1'b0;
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL ring_stop got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        tick_at(1, 20, 1);
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL after_stop got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        $display("test_ring done");
    endtask

    task automatic test_timeout();
        tick_at(1, 20, 0);
        for (int s = 1; s <= 59; s++) tick_at(1, 20, s);
        n_total++;
        if ({state, Alarm} !== {2'd2, 1'b1}) begin
            $display("FAIL tick59_ringing got st=%0d al=%0d exp st=2 al=1", state, Alarm);
            n_bad++;
        end
        tick_at(1, 21, 0);
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL tick60_timeout got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        $display("test_timeout done");
    endtask

    task automatic test_snooze_wrap();
        load(2, 3, 5, 8);
        n_total++;
        if ({state, alarm_hour, alarm_minute} !== {2'd1, 6'd23, 6'd58}) begin
            $display("FAIL load_2358 got st=%0d %0d:%0d exp st=1 23:58", state, alarm_hour, alarm_minute);
            n_bad++;
        end
        tick_at(23, 58, 0);
        tmp_second = 6'd10; snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        n_total++;
        if ({state, Alarm} !== {2'd3, 1'b0}) begin
            $display("FAIL snoozed got st=%0d al=%0d exp st=3 al=0", state, Alarm);
            n_bad++;
        end
        tick_at(0, 2, 59);
        n_total++;
        if ({state, Alarm} !== {2'd3, 1'b0}) begin
            $display("FAIL snz_early got st=%0d al=%0d exp st=3 al=0", state, Alarm);
            n_bad++;
        end
        tick_at(0, 3, 0);
        n_total++;
        if ({state, Alarm} !== {2'd2, 1'b1}) begin
            $display("FAIL snz_wrap_ring got st=%0d al=%0d exp st=2 al=1", state, Alarm);
            n_bad++;
        end
        tmp_second = 6'd5; snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        tick_at(23, 58, 0);
        n_total++;
        if ({state, Alarm} !== {2'd3, 1'b0}) begin
            $display("FAIL snz_ignores_alarm got st=%0d al=%0d exp st=3 al=0", state, Alarm);
            n_bad++;
        end
        STOP_al = 1'b1;
        cyc();
        STOP_al = 1'b0;
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL snz_stop got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        $display("test_snooze_wrap done");
    endtask

    task automatic test_priority();
        tick_at(23, 58, 0);
        AL_ON = 1'b0; snooze = 1'b1;
        cyc();
        n_total++;
        if ({state, Alarm} !== {2'd0, 1'b0}) begin
            $display("FAIL alon_off_wins got st=%0d al=%0d exp st=0 al=0", state, Alarm);
            n_bad++;
        end
        AL_ON = 1'b1; snooze = 1'b0;
        cyc();
        tick_at(23, 58, 0);
        STOP_al = 1'b1; snooze = 1'b1;
        cyc();
        STOP_al = 1'b0; snooze = 1'b0;
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL stop_over_snooze got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        tick_at(23, 58, 0);
        load(0, 1, 2, 0);
        n_total++;
        if ({state, Alarm, alarm_hour, alarm_minute} !== {2'd1, 1'b0, 6'd1, 6'd20}) begin
            $display("FAIL load_in_ring got st=%0d al=%0d %0d:%0d exp st=1 al=0 1:20", state, Alarm, alarm_hour, alarm_minute);
            n_bad++;
        end
        LD_time = 1'b1;
        tick_at(1, 20, 0);
        n_total++;
        if ({state, Alarm} !== {2'd1, 1'b0}) begin
            $display("FAIL ldtime_suppress got st=%0d al=%0d exp st=1 al=0", state, Alarm);
            n_bad++;
        end
        LD_time = 1'b0;
        tick_at(1, 20, 0);
        LD_time = 1'b1;
        tick_at(1, 20, 1);
        LD_time = 1'b0;
        n_total++;
        if ({state, Alarm} !== {2'd2, 1'b1}) begin
            $display("FAIL ldtime_ring_holds got st=%0d al=%0d exp st=2 al=1", state, Alarm);
            n_bad++;
        end
        $display("test_priority done");
    endtask

    task automatic test_async_reset();
        #3 reset = 1'b0;
        #1;
        n_total++;
        if ({state, Alarm, alarm_hour, alarm_minute, alarm_err} !== 16'd0) begin
            $display("FAIL async_reset got=%h exp=0", {state, Alarm, alarm_hour, alarm_minute, alarm_err});
            n_bad++;
        end
        #1 reset = 1'b1;
        #1;
        n_total++;
        if (state !== 2'd0) begin
            $display("FAIL post_reset_idle got st=%0d exp st=0", state);
            n_bad++;
        end
        cyc();
        n_total++;
        if ({state, Alarm, alarm_hour} !== {2'd1, 1'b0, 6'd0}) begin
            $display("FAIL post_reset_arm got st=%0d al=%0d hr=%0d exp st=1 al=0 hr=0", state, Alarm, alarm_hour);
            n_bad++;
        end
        $display("test_async_reset done");
    endtask

    initial begin
        reset = 1'b0; tick_1s = 1'b0;
        tmp_hour = 6'd0; tmp_minute = 6'd0; tmp_second = 6'd0;
        H_in1 = 2'd0; H_in0 = 4'd0; M_in1 = 4'd0; M_in0 = 4'd0;
        LD_alarm = 1'b0; LD_time = 1'b0; AL_ON = 1'b0; STOP_al = 1'b0; snooze = 1'b0;
        #1;
        test_reset();
        test_load();
        test_ring();
        test_timeout();
        test_snooze_wrap();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_seq_ctrl.md
ALARM_SEQ_CTRL -- requirements
Module: alarm_seq_ctrl

Interface
REQ-001 Parameter SNOOZE_MIN, default 5: minutes added to the alarm time per snooze.
REQ-002 Parameter RING_SEC, default 60: maximum ring duration, in tick_1s pulses.
REQ-003 The block SHALL use one clock `clk`; reset is asynchronous and active-low, on port `reset`.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  async active-low reset
- tick_1s  in  1  one-cycle pulse per second, from the counter timebase
- tmp_hour  in  6  current hour, binary 0-23, from clock_counter
- tmp_minute  in  6  current minute, binary 0-59
- tmp_second  in  6  current second, binary 0-59
- H_in1  in  2  alarm hour, tens BCD
- H_in0  in  4  alarm hour, units BCD
- M_in1  in  4  alarm minute, tens BCD
- M_in0  in  4  alarm minute, units BCD
- LD_alarm  in  1  level; load alarm time from the BCD inputs
- LD_time  in  1  level; time load in progress on clock_counter
- AL_ON  in  1  level; alarm enable
- STOP_al  in  1  level; stop ringing
- snooze  in  1  level; snooze request
- Alarm  out  1  ring output, registered
- alarm_hour  out  6  stored alarm hour, binary
- alarm_minute  out  6  stored alarm minute, binary
- alarm_err  out  1  one-cycle pulse on a rejected alarm load
- state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZED=3

Function
REQ-005 The FSM SHALL have states IDLE, ARMED, RINGING and SNOOZED; all outputs SHALL be registered.
REQ-006 LD_alarm high at a clk edge SHALL convert the BCD inputs to binary (H_in1*10+H_in0, M_in1*10+M_in0) and store them in alarm_hour and alarm_minute on that edge.
REQ-007 A load with any BCD digit above 9, hour above 23 or minute above 59 SHALL leave both alarm registers unchanged and pulse alarm_err for exactly 1 cycle.
REQ-008 A valid load SHALL clear the snooze target, set Alarm to 0, and move the state to ARMED if AL_ON=1, otherwise IDLE.
REQ-009 A valid load SHALL apply on every cycle LD_alarm is high; with stable inputs the result is idempotent.
REQ-010 IDLE -> ARMED when AL_ON=1; any state -> IDLE on the next edge when AL_ON=0, with Alarm low on that edge.
REQ-011 Match is defined as tmp_hour==target hour, tmp_minute==target minute, tmp_second==0, and LD_time==0.
REQ-012 Match SHALL be evaluated only on cycles where tick_1s=1, so one match is taken once per occurrence.
REQ-013 The target SHALL be the alarm registers in ARMED and the snooze target in SNOOZED.
REQ-014 ARMED on match -> RINGING; Alarm SHALL be 1 from the same edge; the ring counter SHALL clear.
REQ-015 In RINGING the ring counter SHALL increment per tick_1s; on reaching RING_SEC -> ARMED, with Alarm 0.
REQ-016 RINGING with STOP_al=1 -> ARMED, with Alarm 0 on the next edge; the alarm SHALL retrigger at the same time the next day.
REQ-017 RINGING with snooze=1 and STOP_al=0 -> SNOOZED, with Alarm 0.
REQ-018 On that transition the snooze target SHALL be set to current tmp_hour:tmp_minute + SNOOZE_MIN minutes.
REQ-019 The snooze-target minutes SHALL wrap modulo 60 with a carry into the hour, and the hour SHALL wrap modulo 24 (23:58 + 5 -> 00:03).
REQ-020 SNOOZED on match -> RINGING; STOP_al=1 in SNOOZED -> ARMED.
REQ-021 Same-cycle priority SHALL be, highest first: AL_ON=0, valid LD_alarm, STOP_al, snooze, ring timeout, match.
REQ-022 While LD_time=1 no match SHALL be taken; RINGING and SNOOZED otherwise continue unchanged.

Reset
REQ-023 reset low SHALL immediately, independent of clk, force state=IDLE, Alarm=0, alarm_hour=0, alarm_minute=0, alarm_err=0, snooze target=0 and ring counter=0.
REQ-024 Reset asserted mid-ring SHALL drop Alarm without waiting for a clk edge; after release the block SHALL sit in IDLE until AL_ON is sampled.

Verification
REQ-025 Load: H=0,1 M=2,0 with LD_alarm=1 -> alarm_hour=1, alarm_minute=20, alarm_err=0; then H=2,5 -> alarm_err 1-cycle pulse, registers stay 1:20.
REQ-026 Ring: AL_ON=1, alarm 01:20, counter reaches 01:20:00 with tick_1s -> Alarm=1 and state=2; STOP_al -> Alarm=0, state=1.
REQ-027 Timeout: ring with no user input -> Alarm=0 after exactly 60 ticks, and state=1.
REQ-028 Snooze wrap: alarm 23:58, snooze at 23:58:10 -> state=3; Alarm=1 again at 00:03:00.
REQ-029 Priority and suppression: AL_ON=0 together with snooze while ringing -> state=0, Alarm=0; LD_time=1 during 01:20:00 -> no ring.
REQ-030 Async reset: reset pulsed low mid-ring between clk edges -> Alarm=0 immediately, and all outputs at their reset values.
